// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, access widths
// and the misalignment rule used by the stage and its bench.
package mem_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

  localparam logic [4:0] REG_LINK = 5'd31;

  function automatic logic is_misaligned(input logic mem_type, input logic [1:0] addr_lo);
    return (mem_type == MEM_WORD) && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Little-endian lane steering: store byte enables / data replication and
// zero-extended byte extraction on loads.
module mem_lane_steer
  import mem_stage_pkg::*;
(
  input  logic              wr_type,
  input  logic [1:0]        wr_lane,
  input  logic [DATA_W-1:0] wr_data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  input  logic              rd_type,
  input  logic [1:0]        rd_lane,
  input  logic [DATA_W-1:0] rd_raw,
  output logic [DATA_W-1:0] rd_data
);

  logic [7:0] rd_byte;

  always_comb begin
    be      = 4'hF;
    wdata   = wr_data;
    rd_byte = rd_raw[7:0];
    rd_data = rd_raw;
    if (wr_type == MEM_BYTE) begin
      be    = 4'b0001 << wr_lane;
      wdata = {4{wr_data[7:0]}};
    end
    case (rd_lane)
      2'd0:    rd_byte = rd_raw[7:0];
      2'd1:    rd_byte = rd_raw[15:8];
      2'd2:    rd_byte = rd_raw[23:16];
      default: rd_byte = rd_raw[31:24];
    endcase
    if (rd_type == MEM_BYTE) begin
      rd_data = {24'd0, rd_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch/jump redirect, forwarding probe, single-beat data
// memory access with stall, timeout and misalignment handling, MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic [31:0] pc_branch,
  input  logic        is_jump,
  input  logic [31:0] pc_jump,
  input  logic        alu_zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  input  logic        reg_write,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [4:0]  reg_addr_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        misalign,
  output logic        bus_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, dwe_q, dwe_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, cap_q, cap_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        lane_q, lane_d;
  logic              type_q, type_d, cap_err_q, cap_err_d;
  logic              mtr_q, mtr_d, rw_q, rw_d, misalign_q, misalign_d, bus_error_q, bus_error_d;
  logic [4:0]        ra_q, ra_d;
  logic [31:0]       alu_q, alu_d, md_q, md_d;

  logic              mem_op, bad_op, access;
  logic [3:0]        steer_be;
  logic [31:0]       steer_wdata, steer_rdata;

  assign pc_src      = is_jump | (is_branch & alu_zero);
  assign pc_target   = is_jump ? pc_jump : pc_branch;
  assign reg_probe   = reg_addr;
  assign data_probe  = alu_out;
  assign write_probe = reg_write & ~mem_to_reg;

  // A misaligned word access is dropped as a NOP; load+store is issued as a store.
  assign mem_op = mem_read | mem_write;
  assign bad_op = mem_op & is_misaligned(mem_type, alu_out[1:0]);
  assign access = mem_op & ~bad_op;

  mem_lane_steer u_steer (
    .wr_type (mem_type),
    .wr_lane (alu_out[1:0]),
    .wr_data (data_t),
    .be      (steer_be),
    .wdata   (steer_wdata),
    .rd_type (type_q),
    .rd_lane (lane_q),
    .rd_raw  (dmem_rdata),
    .rd_data (steer_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      dwe_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      lane_q      <= '0;
      type_q      <= 1'b0;
      cap_q       <= '0;
      cap_err_q   <= 1'b0;
      mtr_q       <= 1'b0;
      rw_q        <= 1'b0;
      ra_q        <= '0;
      alu_q       <= '0;
      md_q        <= '0;
      misalign_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      dwe_q       <= dwe_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      lane_q      <= lane_d;
      type_q      <= type_d;
      cap_q       <= cap_d;
      cap_err_q   <= cap_err_d;
      mtr_q       <= mtr_d;
      rw_q        <= rw_d;
      ra_q        <= ra_d;
      alu_q       <= alu_d;
      md_q        <= md_d;
      misalign_q  <= misalign_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack || cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (we) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && access);
  end

  always_comb begin
    cnt_d       = cnt_q;
    req_d       = req_q;
    dwe_d       = dwe_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    lane_d      = lane_q;
    type_d      = type_q;
    cap_d       = cap_q;
    cap_err_d   = cap_err_q;
    mtr_d       = mtr_q;
    rw_d        = rw_q;
    ra_d        = ra_q;
    alu_d       = alu_q;
    md_d        = md_q;
    misalign_d  = misalign_q | bad_op & (state_q == ST_IDLE);
    bus_error_d = bus_error_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          req_d     = 1'b1;
          dwe_d     = mem_write;
          addr_d    = {alu_out[31:2], 2'b00};
          be_d      = steer_be;
          wdata_d   = steer_wdata;
          lane_d    = alu_out[1:0];
          type_d    = mem_type;
          cap_err_d = 1'b0;
        end else if (we) begin
          mtr_d = mem_to_reg;
          rw_d  = reg_write & ~bad_op;
          ra_d  = reg_addr;
          alu_d = alu_out;
          md_d  = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          req_d     = 1'b0;
          cap_d     = steer_rdata;
          cap_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          req_d       = 1'b0;
          cap_d       = '0;
          cap_err_d   = 1'b1;
          bus_error_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (we) begin
          mtr_d = mem_to_reg;
          rw_d  = reg_write & ~cap_err_q;
          ra_d  = reg_addr;
          alu_d = alu_out;
          md_d  = cap_q;
        end
      end
      default: ;
    endcase
  end

  assign dmem_req       = req_q;
  assign dmem_we        = dwe_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign mem_to_reg_out = mtr_q;
  assign reg_write_out  = rw_q;
  assign reg_addr_out   = ra_q;
  assign alu_result_out = alu_q;
  assign mem_data_out   = md_q;
  assign misalign       = misalign_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for redirect/forward/WB paths, hand
// sequences for memory accesses, faults and mid-access reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, we, is_branch, is_jump, alu_zero;
  logic        mem_read, mem_write, mem_type, mem_to_reg, reg_write, dmem_ack;
  logic [31:0] pc_branch, pc_jump, alu_out, data_t, dmem_rdata;
  logic [4:0]  reg_addr;
  logic        pc_src, write_probe, busy, dmem_req, dmem_we;
  logic [31:0] pc_target, data_probe, dmem_addr, dmem_wdata;
  logic [4:0]  reg_probe, reg_addr_out;
  logic [3:0]  dmem_be;
  logic        mem_to_reg_out, reg_write_out, misalign, bus_error;
  logic [31:0] alu_result_out, mem_data_out;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .we(we),
    .is_branch(is_branch), .pc_branch(pc_branch), .is_jump(is_jump), .pc_jump(pc_jump),
    .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_to_reg(mem_to_reg), .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .reg_write(reg_write), .pc_src(pc_src), .pc_target(pc_target), .reg_probe(reg_probe),
    .data_probe(data_probe), .write_probe(write_probe), .busy(busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .reg_addr_out(reg_addr_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .misalign(misalign), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mtr;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] alu;
    logic [31:0] md;
  } wb_t;

  typedef struct {
    logic        is_branch;
    logic [31:0] pc_branch;
    logic        is_jump;
    logic [31:0] pc_jump;
    logic        alu_zero;
    logic        mtr;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] alu;
    logic        exp_src;
    logic [31:0] exp_tgt;
    logic        exp_wp;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop(input logic en);
    we = en; is_branch = 1'b0; is_jump = 1'b0; alu_zero = 1'b0;
    pc_branch = 32'd0; pc_jump = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    mem_type = 1'b0; mem_to_reg = 1'b0; alu_out = 32'd0; data_t = 32'd0;
    reg_addr = 5'd0; reg_write = 1'b0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb: got empty scoreboard, expected a pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_mtr"}, 32'(mem_to_reg_out), 32'(e.mtr));
      check({tag, "_rw"},  32'(reg_write_out),  32'(e.rw));
      check({tag, "_ra"},  32'(reg_addr_out),   32'(e.ra));
      check({tag, "_alu"}, alu_result_out, e.alu);
      check({tag, "_md"},  mem_data_out, e.md);
    end
  endtask

  task automatic do_access(input string tag, input logic rd, input logic wr, input logic typ,
                           input logic [31:0] addr, input logic [31:0] dt, input logic [4:0] ra,
                           input logic rw, input int ack_at, input logic [31:0] rdata,
                           input int exp_busy, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_md,
                           input logic exp_rw);
    int  busy_n;
    bit  done;
    set_nop(1'b1);
    mem_read = rd; mem_write = wr; mem_type = typ; alu_out = addr; data_t = dt;
    reg_addr = ra; reg_write = rw; mem_to_reg = rd & ~wr; dmem_rdata = rdata;
    sb.push_back(wb_t'{rd & ~wr, exp_rw, ra, addr, exp_md});
    busy_n = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      if (k == 1) begin
        check({tag, "_req"},   32'(dmem_req), 32'd1);
        check({tag, "_we"},    32'(dmem_we),  32'(wr));
        check({tag, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"},    32'(dmem_be), 32'(exp_be));
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      end
      dmem_ack = (k == ack_at);
      tick();
    end
    dmem_ack = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_release: busy still high after 40 cycles, expected release", tag);
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
    tick();
    set_nop(1'b1);
    check_wb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 32'h0,  1'b1};
    vecs[1] = '{1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 1'b0, 1'b1, 5'd9,  32'hFFFF_0000, 1'b1, 32'h40, 1'b1};
    vecs[2] = '{1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 5'd3,  32'hA5A5_A5A5, 1'b0, 32'h40, 1'b0};
    vecs[3] = '{1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 5'd31, 32'h8000_0001, 1'b1, 32'h80, 1'b1};
    vecs[4] = '{1'b0, 32'h44, 1'b0, 32'h88, 1'b1, 1'b1, 1'b1, 5'd17, 32'h0000_0007, 1'b0, 32'h44, 1'b0};

    set_nop(1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_req",      32'(dmem_req), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_rw",       32'(reg_write_out), 32'd0);
    check("rst_alu",      alu_result_out, 32'd0);
    check("rst_md",       mem_data_out, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_buserr",   32'(bus_error), 32'd0);
    check("rst_be",       32'(dmem_be), 32'd0);

    for (int i = 0; i < 5; i++) begin
      set_nop(1'b1);
      is_branch = vecs[i].is_branch; pc_branch = vecs[i].pc_branch;
      is_jump = vecs[i].is_jump; pc_jump = vecs[i].pc_jump; alu_zero = vecs[i].alu_zero;
      mem_to_reg = vecs[i].mtr; reg_write = vecs[i].rw; reg_addr = vecs[i].ra;
      alu_out = vecs[i].alu;
      #1;
      check($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].exp_src));
      check($sformatf("v%0d_pc_target", i), pc_target, vecs[i].exp_tgt);
      check($sformatf("v%0d_write_probe", i), 32'(write_probe), 32'(vecs[i].exp_wp));
      check($sformatf("v%0d_reg_probe", i), 32'(reg_probe), 32'(vecs[i].ra));
      check($sformatf("v%0d_data_probe", i), data_probe, vecs[i].alu);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      sb.push_back(wb_t'{vecs[i].mtr, vecs[i].rw, vecs[i].ra, vecs[i].alu, 32'd0});
      tick();
      check($sformatf("v%0d_req", i), 32'(dmem_req), 32'd0);
      check_wb($sformatf("v%0d", i));
    end

    do_access("lw_100", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 2, 32'hDEAD_BEEF,
              3, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    do_access("sb_203", 1'b0, 1'b1, 1'b1, 32'h203, 32'h0000_00AB, 5'd0, 1'b0, 1, 32'h0,
              2, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
    do_access("lb_101", 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 5'd8, 1'b1, 1, 32'h1122_3344,
              2, 4'b0010, 32'h0, 32'h0000_0033, 1'b1);
    do_access("sw_rw", 1'b1, 1'b1, 1'b0, 32'h204, 32'h1357_9BDF, 5'd0, 1'b0, 1, 32'h0,
              2, 4'hF, 32'h1357_9BDF, 32'h0, 1'b0);
    check("buserr_clean", 32'(bus_error), 32'd0);

    set_nop(1'b1);
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h102; reg_addr = 5'd4; reg_write = 1'b1;
    #1;
    check("lw_bad_busy", 32'(busy), 32'd0);
    sb.push_back(wb_t'{1'b1, 1'b0, 5'd4, 32'h102, 32'd0});
    tick();
    check("lw_bad_req", 32'(dmem_req), 32'd0);
    check("lw_bad_misalign", 32'(misalign), 32'd1);
    check_wb("lw_bad");

    set_nop(1'b1);
    mem_write = 1'b1; alu_out = 32'h102; data_t = 32'h5555_AAAA;
    #1;
    check("sw_bad_busy", 32'(busy), 32'd0);
    sb.push_back(wb_t'{1'b0, 1'b0, 5'd0, 32'h102, 32'd0});
    tick();
    check("sw_bad_req", 32'(dmem_req), 32'd0);
    check_wb("sw_bad");
    check("misalign_sticky", 32'(misalign), 32'd1);

    do_access("lw_ack_edge", 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1, 16, 32'hCAFE_F00D,
              17, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
    check("buserr_edge", 32'(bus_error), 32'd0);

    do_access("lw_timeout", 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd11, 1'b1, -1, 32'h0,
              17, 4'hF, 32'h0, 32'h0, 1'b0);
    check("buserr_set", 32'(bus_error), 32'd1);

    set_nop(1'b1);
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h400; reg_addr = 5'd6; reg_write = 1'b1;
    tick();
    tick();
    check("rstw_req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_nop(1'b0);
    #1;
    check("rstw_req",      32'(dmem_req), 32'd0);
    check("rstw_busy",     32'(busy), 32'd0);
    check("rstw_alu",      alu_result_out, 32'd0);
    check("rstw_ra",       32'(reg_addr_out), 32'd0);
    check("rstw_mtr",      32'(mem_to_reg_out), 32'd0);
    check("rstw_buserr",   32'(bus_error), 32'd0);
    check("rstw_misalign", 32'(misalign), 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    check("late_ack_md",   mem_data_out, 32'd0);
    check("late_ack_rw",   32'(reg_write_out), 32'd0);
    check("late_ack_req",  32'(dmem_req), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);

    set_nop(1'b1);
    alu_out = 32'h55; reg_addr = 5'd2; reg_write = 1'b1;
    sb.push_back(wb_t'{1'b0, 1'b1, 5'd2, 32'h55, 32'd0});
    tick();
    check_wb("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register and drives the data-memory request/acknowledge bus.
- Resolves branch/jump redirection, exposes a forwarding probe, stalls the pipeline while a load/store is outstanding, and registers results into the MEM/WB pipeline register.
- Handles word and byte accesses with little-endian lane steering, misalignment detection and a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT without dmem_ack before the access is aborted (>=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  pipeline advance enable from hazard unit
- is_branch  in  1  conditional branch in this slot
- pc_branch  in  32  branch target
- is_jump  in  1  jump in this slot
- pc_jump  in  32  jump target
- alu_zero  in  1  ALU zero flag
- mem_read  in  1  load
- mem_write  in  1  store
- mem_type  in  1  0=word, 1=byte
- mem_to_reg  in  1  writeback selects memory data
- alu_out  in  32  ALU result / effective address
- data_t  in  32  store data
- reg_addr  in  5  destination register
- reg_write  in  1  register write enable
- pc_src  out  1  redirect fetch
- pc_target  out  32  redirect address
- reg_probe  out  5  forwarding: destination register
- data_probe  out  32  forwarding: ALU value
- write_probe  out  1  forwarding valid
- busy  out  1  stall request to upstream stages
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address (bits[1:0]=0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  single-cycle completion
- mem_to_reg_out  out  1  WB: select memory data
- reg_write_out  out  1  WB: write enable
- reg_addr_out  out  5  WB: destination
- alu_result_out  out  32  WB: ALU value
- mem_data_out  out  32  WB: load data
- misalign  out  1  sticky: misaligned word access seen
- bus_error  out  1  sticky: timeout seen

Behaviour:
- Reset: every registered output is 0, FSM enters IDLE, counter is 0. This holds mid-access: dmem_req drops on the next cycle, and a late dmem_ack is ignored in IDLE.
- Combinational outputs:
  - pc_src = is_jump | (is_branch & alu_zero).
  - pc_target = is_jump ? pc_jump : pc_branch.
  - reg_probe = reg_addr, data_probe = alu_out, write_probe = reg_write & ~mem_to_reg.
- access = (mem_read | mem_write) & ~bad, where bad = (mem_type==0) & (alu_out[1:0]!=0).
- A bad access is treated as a NOP: no bus cycle, write suppressed (reg_write_out=0 on load), misalign set (sticky).
- FSM IDLE:
  - busy = access.
  - If access: latch address/data/be, drive dmem_req=1 registered, go to WAIT.
  - Otherwise, if we: load WB register (mem_data_out=0).
- FSM WAIT:
  - busy=1, dmem_req held, counter increments.
  - On dmem_ack: capture the steered rdata, go to DONE.
  - If counter==TIMEOUT_CYCLES-1 with no ack: set bus_error, capture data 0, force reg_write_out=0 for this slot, go to DONE.
  - Requests and ack are single-beat; ack in the same cycle as timeout counts as success.
- FSM DONE:
  - busy=0, dmem_req=0.
  - If we: load WB register with captured data, go to IDLE. Else hold in DONE. No re-issue of the same instruction.
- Minimum access latency: 3 cycles of stage occupancy (IDLE, WAIT with ack, DONE), i.e. busy high for 2 cycles.
- Byte store: dmem_be = 1 << alu_out[1:0]; dmem_wdata = {4{data_t[7:0]}}.
- Word store: be=4'hF, wdata=data_t.
- Byte load: zero-extended rdata lane alu_out[1:0] (lane 0 = bits 7:0).
- dmem_addr = {alu_out[31:2],2'b00}. dmem_we = mem_write.
- mem_read & mem_write together: treated as a store.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (IDLE/WAIT/DONE).
  - MEM_WORD/MEM_BYTE constants.
  - Link register index 31.
- One sub-module: mem_lane_steer (combinational byte-enable, write-data replication and read-lane extraction).

Test Plan:
- Non-memory op, alu_out=0x1234, reg_addr=5, reg_write=1, we=1 -> next edge alu_result_out=0x1234, reg_addr_out=5, reg_write_out=1; busy and dmem_req stay 0.
- Word load addr 0x100, ack 2 cycles after req with rdata 0xDEADBEEF -> dmem_addr=0x100, be=4'hF, busy high 3 cycles, then mem_data_out=0xDEADBEEF, mem_to_reg_out=1.
- Byte store addr 0x203, data_t=0x000000AB -> dmem_we=1, be=4'b1000, wdata=0xABABABAB. Byte load addr 0x101 with rdata 0x11223344 -> mem_data_out=0x00000033.
- Word store addr 0x102 -> no dmem_req, misalign=1, busy=0. Word load with ack never asserted -> after 16 WAIT cycles bus_error=1, reg_write_out=0, busy releases.
- is_branch=1, alu_zero=1, pc_branch=0x40 -> pc_src=1, pc_target=0x40. is_jump=1, pc_jump=0x80 -> pc_target=0x80.
- Reset asserted in WAIT -> dmem_req=0 and all outputs 0 next cycle. Ack arriving one cycle later -> ignored, no WB load.
